// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity-mode constants, rx state encoding and parity helper
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd2;
  localparam logic [1:0] PAR_ODD  = 2'd3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Parity bit the transmitter should have sent: XOR of data, inverted for odd parity.
  function automatic logic exp_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer with selectable reset level
module uart_sync #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next-state of the two synchronizer stages.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Stages reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      s1_q <= RESET_LEVEL;
      s2_q <= RESET_LEVEL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with mid-bit sampling, optional parity and framing check
module uart_rx
  import uart_pkg::*;
#(
  parameter int   CLK_DIV_WIDTH = 8,
  parameter logic START_BIT     = 1'b0,
  parameter logic STOP_BIT      = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic                     rx,
  input  logic [1:0]               parity_mode,
  output logic [7:0]               datao,
  output logic                     valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     busy
);

  logic                     rxs;
  logic [2:0]               state_q, state_d;
  logic [CLK_DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [CLK_DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]               par_mode_q, par_mode_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic                     par_bit_q, par_bit_d;
  logic                     armed_q, armed_d;
  logic                     valid_q, valid_d;
  logic [7:0]               datao_q, datao_d;
  logic                     parity_err_q, parity_err_d;
  logic                     frame_err_q, frame_err_d;
  logic                     half_end, period_end, par_en, par_odd;

  uart_sync #(.RESET_LEVEL(STOP_BIT)) u_sync (
    .clk    (clk),
    .resetb (resetb),
    .d      (rx),
    .q      (rxs)
  );

  // Timing uses the divisor captured at start detection, never the live input.
  assign half_end   = (cnt_q == (div_q >> 1) - 1'b1);
  assign period_end = (cnt_q == div_q - 1'b1);
  assign par_en     = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
  assign par_odd    = (par_mode_q == PAR_ODD);

  // Frame FSM: start qualification, bit sampling and result capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    div_d        = div_q;
    par_mode_d   = par_mode_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    armed_d      = armed_q;
    valid_d      = 1'b0;
    datao_d      = datao_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        armed_d = armed_q | (rxs == STOP_BIT);
        if (armed_q && rxs == START_BIT) begin
          div_d      = clk_div;
          par_mode_d = parity_mode;
          bit_cnt_d  = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (half_end) begin
          cnt_d   = '0;
          state_d = (rxs == START_BIT) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (period_end) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (period_end) begin
          cnt_d     = '0;
          par_bit_d = rxs;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (period_end) begin
          cnt_d        = '0;
          valid_d      = 1'b1;
          datao_d      = shift_q;
          parity_err_d = par_en && (par_bit_q != exp_parity(shift_q, par_odd));
          frame_err_d  = (rxs != STOP_BIT);
          state_d      = (rxs == STOP_BIT) ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rxs == STOP_BIT) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      par_mode_q   <= PAR_NONE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      armed_q      <= 1'b0;
      valid_q      <= 1'b0;
      datao_q      <= 8'h00;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      par_mode_q   <= par_mode_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      armed_q      <= armed_d;
      valid_q      <= valid_d;
      datao_q      <= datao_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign datao      = datao_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       resetb;
  logic       rx;
  logic [7:0] clk_div;
  logic [1:0] parity_mode;
  logic [7:0] datao;
  logic       valid, parity_err, frame_err, busy;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t ev_q[$];
  ev_t exp_q[$];

  uart_rx #(.CLK_DIV_WIDTH(8), .START_BIT(1'b0), .STOP_BIT(1'b1)) dut (
    .clk         (clk),
    .resetb      (resetb),
    .clk_div     (clk_div),
    .rx          (rx),
    .parity_mode (parity_mode),
    .datao       (datao),
    .valid       (valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (resetb === 1'b1 && valid === 1'b1)
      ev_q.push_back({datao, parity_err, frame_err, 32'(cyc)});
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serialize one frame and predict its result: bytes LSB first, the valid pulse
  // 3 cycles after the stop-bit midpoint (start edge + div/2 + nb*div).
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input int div,
                            input logic flip_par, input logic stop_low);
    logic good_pb, sent_pb;
    int   nb;
    ev_t  e;
    good_pb = ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ mode[0];
    sent_pb = good_pb ^ flip_par;
    nb      = mode[1] ? 10 : 9;
    e.d     = d;
    e.pe    = mode[1] && (sent_pb != good_pb);
    e.fe    = stop_low;
    e.cyc   = 32'(cyc + 3 + div / 2 + nb * div);
    exp_q.push_back(e);
    clk_div     = 8'(div);
    parity_mode = mode;
    rx = 1'b0;
    tick(div);
    clk_div     = 8'($urandom_range(4, 255));
    parity_mode = 2'($urandom_range(0, 3));
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(div);
    end
    if (mode[1]) begin
      rx = sent_pb;
      tick(div);
    end
    rx = ~stop_low;
    tick(div);
  endtask

  task automatic test_reset();
    resetb = 1'b0; rx = 1'b1; clk_div = 8'd16; parity_mode = PAR_NONE;
    tick(3);
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (datao !== 8'h00) $display("FAIL reset_datao: got %h expected 00", datao); else n_pass++;
    n_checks++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b expected 0", parity_err); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else n_pass++;
    resetb = 1'b1;
    tick(4);
  endtask

  task automatic test_basic();
    ev_q.delete(); exp_q.delete();
    send_frame(8'hA5, PAR_NONE, 16, 1'b0, 1'b0);
    tick(8);
    n_checks++;
    if (ev_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL basic_ev%0d: got d=%h pe=%b fe=%b cyc=%0d expected d=%h pe=%b fe=%b cyc=%0d", i,
                 ev_q[i].d, ev_q[i].pe, ev_q[i].fe, ev_q[i].cyc, exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_parity();
    ev_q.delete(); exp_q.delete();
    send_frame(8'h03, PAR_EVEN, 16, 1'b0, 1'b0);
    tick(5);
    send_frame(8'h03, PAR_EVEN, 16, 1'b1, 1'b0);
    tick(8);
    n_checks++;
    if (ev_q.size() != exp_q.size()) $display("FAIL parity_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL parity_ev%0d: got d=%h pe=%b fe=%b cyc=%0d expected d=%h pe=%b fe=%b cyc=%0d", i,
                 ev_q[i].d, ev_q[i].pe, ev_q[i].fe, ev_q[i].cyc, exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int busy_seen = 0;
    int low_at = -1;
    ev_q.delete();
    clk_div = 8'd16; parity_mode = PAR_NONE;
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (busy === 1'b1) busy_seen = 1;
    end
    rx = 1'b1;
    for (int i = 1; i <= 9 && low_at < 0; i++) begin
      tick(1);
      if (busy === 1'b0) low_at = i;
    end
    tick(40);
    n_checks++; if (busy_seen != 1) $display("FAIL glitch_busy_seen: got %0d expected 1", busy_seen); else n_pass++;
    n_checks++; if (low_at < 0) $display("FAIL glitch_busy_low: got still busy after 9 cycles expected idle"); else n_pass++;
    n_checks++; if (ev_q.size() != 0) $display("FAIL glitch_no_valid: got %0d pulses expected 0", ev_q.size()); else n_pass++;
    n_checks++; if (datao !== 8'h03) $display("FAIL glitch_hold_datao: got %h expected 03", datao); else n_pass++;
    n_checks++; if (parity_err !== 1'b1) $display("FAIL glitch_hold_perr: got %b expected 1", parity_err); else n_pass++;
  endtask

  task automatic test_break();
    int low_at = -1;
    ev_q.delete(); exp_q.delete();
    send_frame(8'h00, PAR_NONE, 16, 1'b0, 1'b1);
    tick(24);
    n_checks++; if (busy !== 1'b1) $display("FAIL break_busy_high: got %b expected 1", busy); else n_pass++;
    rx = 1'b1;
    for (int i = 1; i <= 8 && low_at < 0; i++) begin
      tick(1);
      if (busy === 1'b0) low_at = i;
    end
    n_checks++; if (low_at < 0) $display("FAIL break_busy_low: got still busy after 8 cycles expected idle"); else n_pass++;
    tick(4);
    send_frame(8'h5A, PAR_NONE, 16, 1'b0, 1'b0);
    tick(8);
    n_checks++;
    if (ev_q.size() != exp_q.size()) $display("FAIL break_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL break_ev%0d: got d=%h pe=%b fe=%b cyc=%0d expected d=%h pe=%b fe=%b cyc=%0d", i,
                 ev_q[i].d, ev_q[i].pe, ev_q[i].fe, ev_q[i].cyc, exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    ev_q.delete(); exp_q.delete();
    send_frame(8'h00, PAR_ODD, 8, 1'b0, 1'b0);
    send_frame(8'hFF, PAR_ODD, 8, 1'b0, 1'b0);
    send_frame(8'h55, PAR_ODD, 8, 1'b0, 1'b0);
    tick(8);
    n_checks++;
    if (ev_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL b2b_ev%0d: got d=%h pe=%b fe=%b cyc=%0d expected d=%h pe=%b fe=%b cyc=%0d", i,
                 ev_q[i].d, ev_q[i].pe, ev_q[i].fe, ev_q[i].cyc, exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    ev_q.delete(); exp_q.delete();
    d = 8'h3C;
    clk_div = 8'd16; parity_mode = PAR_NONE;
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(16);
    end
    rx = d[4];
    tick(8);
    resetb = 1'b0; rx = 1'b1;
    tick(1);
    n_checks++; if (valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (datao !== 8'h00) $display("FAIL rmid_datao: got %h expected 00", datao); else n_pass++;
    n_checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL rmid_errs: got pe=%b fe=%b expected 0 0", parity_err, frame_err); else n_pass++;
    tick(2);
    resetb = 1'b1;
    tick(40);
    n_checks++; if (ev_q.size() != 0) $display("FAIL rmid_no_valid: got %0d pulses expected 0", ev_q.size()); else n_pass++;
    send_frame(8'hC3, PAR_EVEN, 16, 1'b0, 1'b0);
    tick(8);
    n_checks++;
    if (ev_q.size() != exp_q.size()) $display("FAIL rmid_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL rmid_ev%0d: got d=%h pe=%b fe=%b cyc=%0d expected d=%h pe=%b fe=%b cyc=%0d", i,
                 ev_q[i].d, ev_q[i].pe, ev_q[i].fe, ev_q[i].cyc, exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] last_d;
    ev_q.delete(); exp_q.delete();
    last_d = 8'h00;
    for (int f = 0; f < 10; f++) begin
      tick($urandom_range(0, 2));
      last_d = 8'($urandom_range(0, 255));
      send_frame(last_d, 2'($urandom_range(0, 3)), $urandom_range(4, 20),
                 1'($urandom_range(0, 1)), 1'b0);
    end
    tick(30);
    n_checks++;
    if (ev_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d pulses expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL rand_ev%0d: got d=%h pe=%b fe=%b cyc=%0d expected d=%h pe=%b fe=%b cyc=%0d", i,
                 ev_q[i].d, ev_q[i].pe, ev_q[i].fe, ev_q[i].cyc, exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
      else n_pass++;
    end
    n_checks++; if (datao !== last_d) $display("FAIL rand_hold_datao: got %h expected %h", datao, last_d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV_WIDTH, 8, width of the bit-period divisor.
REQ-002 SHALL have parameter START_BIT, 0, expected line level of the start bit.
REQ-003 SHALL have parameter STOP_BIT, 1, expected line level of the stop bit and of the idle line.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port resetb  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clk_div  input  CLK_DIV_WIDTH  bit period in clk cycles; supported range 4..2^CLK_DIV_WIDTH-1.
REQ-007 SHALL have port rx  input  1  asynchronous serial line.
REQ-008 SHALL have port parity_mode  input  2  0 or 1 = none, 2 = even, 3 = odd.
REQ-009 SHALL have port datao  output  8  last received byte.
REQ-010 SHALL have port valid  output  1  one-cycle pulse; datao and the error flags are valid in this cycle.
REQ-011 SHALL have port parity_err  output  1  parity mismatch for the byte flagged by valid.
REQ-012 SHALL have port frame_err  output  1  stop bit not at STOP_BIT level for the byte flagged by valid.
REQ-013 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer reset to STOP_BIT; all logic SHALL use only the synchronized signal rxs.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-016 IDLE: when rxs == START_BIT, SHALL latch clk_div into a frame-local register, clear the bit counter, and enter START.
REQ-017 START: after clk_div>>1 cycles, SHALL re-sample rxs; START_BIT level -> DATA; otherwise -> IDLE as a glitch, with no valid and no error.
REQ-018 DATA: SHALL sample rxs every latched clk_div cycles, 8 samples, LSB first, into a shift register.
REQ-019 After the 8th sample SHALL go to PARITY if parity_mode[1] is 1, else to STOP.
REQ-020 PARITY: after one period SHALL sample the parity bit.
REQ-021 Expected parity bit SHALL be XOR(data) when parity_mode[0] is 0, and ~XOR(data) when it is 1.
REQ-022 STOP: after one period SHALL sample the stop bit, then in the next cycle pulse valid for exactly one cycle and load datao, parity_err and frame_err.
REQ-023 parity_err SHALL be 0 when parity is disabled.
REQ-024 After STOP, SHALL go to IDLE if rxs == STOP_BIT, else to WAIT_IDLE.
REQ-025 WAIT_IDLE (break or frame error) SHALL stay until rxs == STOP_BIT, then go to IDLE; no start detection in this state.
REQ-026 Each bit sample SHALL fall clk_div>>1 cycles after the detected start edge plus whole periods (mid-bit).
REQ-027 The valid pulse SHALL occur at a fixed latency of 2 synchronizer + 1 output cycles after the stop-bit mid-point.
REQ-028 A change of clk_div or parity_mode mid-frame SHALL NOT affect the current frame; parity_mode SHALL be latched with clk_div.
REQ-029 datao, parity_err and frame_err SHALL hold their values between valid pulses.
REQ-030 There SHALL be no backpressure; a new byte overwrites datao.
REQ-031 A new start bit SHALL be accepted in the cycle immediately after STOP returns to IDLE, so back-to-back frames at STOP_BIT length 1 are received.

Reset
REQ-032 While resetb is low at a clk edge: state = IDLE, valid = 0, busy = 0, parity_err = 0, frame_err = 0, datao = 0x00, counters = 0, synchronizer = STOP_BIT.
REQ-033 Reset mid-frame SHALL discard the partial byte with no valid pulse.
REQ-034 The first start detection after reset release SHALL require rxs at STOP_BIT level for at least one cycle.

Structure
REQ-035 Shared package uart_pkg SHALL hold the parity_mode constants PAR_NONE = 0, PAR_EVEN = 2, PAR_ODD = 3 and the rx state encoding.
REQ-036 The synchronizer SHALL be a sub-module uart_sync, parameterized by reset level.
REQ-037 The bit-period counter and FSM SHALL stay in uart_rx.

Verification
REQ-038 clk_div = 16, no parity, send 0xA5 -> one valid pulse, datao = 0xA5, parity_err = 0, frame_err = 0.
REQ-039 clk_div = 16, even parity, send 0x03 with parity bit 0 -> parity_err = 0; same byte with parity bit 1 -> parity_err = 1, datao = 0x03.
REQ-040 rx low for 5 cycles then high, clk_div = 16 -> no valid pulse, busy returns low within 9 cycles.
REQ-041 Send 0x00 with the stop bit held low for 40 cycles -> valid with frame_err = 1, busy high until rx goes high; a following 0x5A is received cleanly.
REQ-042 Loopback from uart_tx, clk_div = 8, odd parity, back-to-back 0x00, 0xFF, 0x55 -> three valid pulses, correct bytes, no errors.
REQ-043 Assert resetb low in the middle of bit 4 of a frame -> no valid pulse, all outputs at their reset values, the next full frame is received correctly.
